seg_scan_driver: RTL and testbench

//  Time-multiplexed 8-digit 7-segment display driver, sitting downstream of the 32-bit counter/nibble-select path.

---
 rtl/seg_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed 7-segment driver.
// A 32-bit value and 8 decimal points are captured on load. The digits are
// scanned one slot of REFRESH_DIV clocks at a time, and each slot starts with
// BLANK_CYC clocks of all-anodes-off so the previous digit cannot ghost.
// All board-facing outputs are registered, one clock behind the scan state.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_sel
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam int BW = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    // BLANK: anodes forced off at the start of a slot; DRIVE: digit shown.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    dp_shadow_q, dp_shadow_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [2:0]    digit_sel_q, digit_sel_d;

    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic          lz_blank;

    // Refresh prescaler; tick marks the last clock of each digit slot.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Scan FSM next state: a tick always starts a new slot on the next digit.
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        idx_d       = idx_q;
        if (tick) begin
            idx_d       = idx_q + 3'd1;
            blank_cnt_d = '0;
            state_d     = (BLANK_CYC > 0) ? ST_BLANK : ST_DRIVE;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                    // With no blank gap configured, leave the reset BLANK state at once.
                    if ((BLANK_CYC == 0) || (blank_cnt_q == BLANK_LAST)) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state_d = ST_DRIVE;
                end
                default: begin
                    state_d = ST_BLANK;
                end
            endcase
        end
    end

    // Shadow capture happens on any loaded edge, not deferred to a slot boundary.
    always_comb begin
        shadow_d    = load ? data_in : shadow_q;
        dp_shadow_d = load ? dp_in   : dp_shadow_q;
    end

    // Current nibble, hex decode and leading-zero detection.
    always_comb begin
        nibble   = shadow_q[{idx_q, 2'b00} +: 4];
        lz_blank = LZ_SUPPRESS && (idx_q != 3'd0) &&
                   ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
        case (nibble)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    // Output register inputs: everything dark in BLANK, selected digit in DRIVE.
    always_comb begin
        an_d        = 8'hFF;
        seg_d       = 7'h7F;
        dp_d        = 1'b1;
        digit_sel_d = idx_q;
        if (state_q == ST_DRIVE) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = lz_blank ? 7'h7F : seg_dec;
            dp_d  = ~dp_shadow_q[idx_q];
        end
    end

    // State and output registers, asynchronously cleared to the dark display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_BLANK;
            presc_q     <= '0;
            blank_cnt_q <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= 32'd0;
            dp_shadow_q <= 8'd0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            digit_sel_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blank_cnt_q <= blank_cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4. Three instances share the
// inputs: the main one (BLANK_CYC=1, LZ on), one with LZ off and one with
// no blank gap. Inputs change on the falling edge; outputs are sampled there.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        load;
    logic [7:0]  dp_in;

    logic [7:0]  an_m, an_z, an_n;
    logic [6:0]  seg_m, seg_z, seg_n;
    logic        dp_m, dp_z, dp_n;
    logic [2:0]  sel_m, sel_z, sel_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1), .LZ_SUPPRESS(1'b1)) u_main (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
        .an(an_m), .seg(seg_m), .dp(dp_m), .digit_sel(sel_m)
    );

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1), .LZ_SUPPRESS(1'b0)) u_lz0 (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
        .an(an_z), .seg(seg_z), .dp(dp_z), .digit_sel(sel_z)
    );

    seg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(0), .LZ_SUPPRESS(1'b1)) u_nb (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
        .an(an_n), .seg(seg_n), .dp(dp_n), .digit_sel(sel_n)
    );

    // Hold reset across several clocks, then release on a falling edge.
    task automatic test_reset();
        rst = 1'b0; load = 1'b0; data_in = 32'd0; dp_in = 8'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (an_m !== 8'hFF || seg_m !== 7'h7F || dp_m !== 1'b1 || sel_m !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold: an=%h seg=%h dp=%b sel=%0d, want an=ff seg=7f dp=1 sel=0",
                         an_m, seg_m, dp_m, sel_m);
            end
            checks++;
            if (an_z !== 8'hFF || an_n !== 8'hFF) begin
                errors++;
                $display("FAIL reset_hold_other: an_lz0=%h an_nb=%h, want ff", an_z, an_n);
            end
        end
        rst = 1'b1;
    endtask

    // One full scan of zero data right after reset, LZ on and off.
    task automatic test_reset_scan();
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (an_m !== 8'hFF || seg_m !== 7'h7F || dp_m !== 1'b1 || sel_m !== 3'(k)) begin
                errors++;
                $display("FAIL zero_blank d%0d: an=%h seg=%h dp=%b sel=%0d, want an=ff seg=7f dp=1 sel=%0d",
                         k, an_m, seg_m, dp_m, sel_m, k);
            end
            exp_an  = ~(8'h01 << k);
            exp_seg = (k == 0) ? 7'h40 : 7'h7F;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                checks++;
                if (an_m !== exp_an || seg_m !== exp_seg || dp_m !== 1'b1 || sel_m !== 3'(k)) begin
                    errors++;
                    $display("FAIL zero_drive d%0d: an=%h seg=%h dp=%b sel=%0d, want an=%h seg=%h dp=1 sel=%0d",
                             k, an_m, seg_m, dp_m, sel_m, exp_an, exp_seg, k);
                end
                checks++;
                if (an_z !== exp_an || seg_z !== 7'h40) begin
                    errors++;
                    $display("FAIL no_lz_drive d%0d: an=%h seg=%h, want an=%h seg=40",
                             k, an_z, seg_z, exp_an);
                end
            end
        end
    endtask

    // Load two patterns at a slot boundary and check a full scan of each.
    task automatic test_load_scan();
        logic [31:0] vec_data [2];
        logic [7:0]  vec_dp   [2];
        logic [6:0]  seg_tab  [2][8];
        logic [7:0]  exp_an;
        logic        exp_dp;
        vec_data[0] = 32'h1234ABCD; vec_dp[0] = 8'h01;
        seg_tab[0]  = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        vec_data[1] = 32'h000000F0; vec_dp[1] = 8'h04;
        seg_tab[1]  = '{7'h40, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int v = 0; v < 2; v++) begin
            data_in = vec_data[v];
            dp_in   = vec_dp[v];
            load    = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                load = 1'b0;
                checks++;
                if (an_m !== 8'hFF || seg_m !== 7'h7F || dp_m !== 1'b1 || sel_m !== 3'(k)) begin
                    errors++;
                    $display("FAIL load_blank v%0d d%0d: an=%h seg=%h dp=%b sel=%0d, want an=ff seg=7f dp=1 sel=%0d",
                             v, k, an_m, seg_m, dp_m, sel_m, k);
                end
                exp_an = ~(8'h01 << k);
                exp_dp = ~vec_dp[v][k];
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    checks++;
                    if (an_m !== exp_an || seg_m !== seg_tab[v][k] || dp_m !== exp_dp || sel_m !== 3'(k)) begin
                        errors++;
                        $display("FAIL load_drive v%0d d%0d: an=%h seg=%h dp=%b sel=%0d, want an=%h seg=%h dp=%b sel=%0d",
                                 v, k, an_m, seg_m, dp_m, sel_m, exp_an, seg_tab[v][k], exp_dp, k);
                    end
                end
            end
        end
    endtask

    // Load all-F on the same edge as a slot tick; next slot must show F.
    task automatic test_load_on_tick();
        @(negedge clk);
        checks++;
        if (an_m !== 8'hFF) begin
            errors++;
            $display("FAIL tick_pre_blank: an=%h, want ff", an_m);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (an_m !== 8'hFE || seg_m !== 7'h40) begin
                errors++;
                $display("FAIL tick_pre_drive: an=%h seg=%h, want an=fe seg=40", an_m, seg_m);
            end
        end
        data_in = 32'hFFFFFFFF;
        dp_in   = 8'h00;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (an_m !== 8'hFE || seg_m !== 7'h40) begin
            errors++;
            $display("FAIL tick_load_edge: an=%h seg=%h, want an=fe seg=40", an_m, seg_m);
        end
        @(negedge clk);
        checks++;
        if (an_m !== 8'hFF || seg_m !== 7'h7F || sel_m !== 3'd1) begin
            errors++;
            $display("FAIL tick_post_blank: an=%h seg=%h sel=%0d, want an=ff seg=7f sel=1", an_m, seg_m, sel_m);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (an_m !== 8'hFD || seg_m !== 7'h0E || dp_m !== 1'b1 || sel_m !== 3'd1) begin
                errors++;
                $display("FAIL tick_post_drive: an=%h seg=%h dp=%b sel=%0d, want an=fd seg=0e dp=1 sel=1",
                         an_m, seg_m, dp_m, sel_m);
            end
        end
    endtask

    // Asynchronous reset in the middle of digit 5's drive phase.
    task automatic test_reset_mid_scan();
        repeat (13) @(negedge clk);
        @(negedge clk);
        checks++;
        if (an_m !== 8'hDF || seg_m !== 7'h0E || sel_m !== 3'd5) begin
            errors++;
            $display("FAIL mid_before: an=%h seg=%h sel=%0d, want an=df seg=0e sel=5", an_m, seg_m, sel_m);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (an_m !== 8'hFF || seg_m !== 7'h7F || dp_m !== 1'b1 || sel_m !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: an=%h seg=%h dp=%b sel=%0d, want an=ff seg=7f dp=1 sel=0",
                     an_m, seg_m, dp_m, sel_m);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an_m !== 8'hFF || sel_m !== 3'd0) begin
            errors++;
            $display("FAIL mid_restart_blank: an=%h sel=%0d, want an=ff sel=0", an_m, sel_m);
        end
        @(negedge clk);
        checks++;
        if (an_m !== 8'hFE || seg_m !== 7'h40 || dp_m !== 1'b1 || sel_m !== 3'd0) begin
            errors++;
            $display("FAIL mid_restart_d0: an=%h seg=%h dp=%b sel=%0d, want an=fe seg=40 dp=1 sel=0",
                     an_m, seg_m, dp_m, sel_m);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (an_m !== 8'hFF || sel_m !== 3'd1) begin
            errors++;
            $display("FAIL mid_restart_blank1: an=%h sel=%0d, want an=ff sel=1", an_m, sel_m);
        end
        @(negedge clk);
        checks++;
        if (an_m !== 8'hFD || seg_m !== 7'h7F) begin
            errors++;
            $display("FAIL mid_shadow_lost: an=%h seg=%h, want an=fd seg=7f", an_m, seg_m);
        end
    endtask

    // No blank gap: after the first clock, anodes step every 4 clocks.
    task automatic test_no_blank();
        logic [7:0] exp_an;
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (an_n !== 8'hFF) begin
            errors++;
            $display("FAIL nb_first: an=%h, want ff", an_n);
        end
        for (int c = 2; c < 34; c++) begin
            @(negedge clk);
            exp_an = ~(8'h01 << (((c - 1) / 4) % 8));
            checks++;
            if (an_n !== exp_an) begin
                errors++;
                $display("FAIL nb_scan c%0d: an=%h, want %h", c, an_n, exp_an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_scan();
        test_load_scan();
        test_load_on_tick();
        test_reset_mid_scan();
        test_no_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want bench completion");
        $fatal(1, "watchdog");
    end

endmodule
